// File: rtl/cpu_collector_pkg.sv
// cpu_collector_pkg: shared types and round-robin helper for the cpu collector.
package cpu_collector_pkg;
  typedef logic [63:0] cpu_data_t;
  typedef logic [31:0] cpu_idx_t;
  // First set req bit at or after ptr, wrapping at n; returns ptr when req is empty.
  function automatic cpu_idx_t next_rr(input cpu_idx_t ptr, input logic [31:0] req, input int n);
    cpu_idx_t c;
    next_rr = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      c = ptr + cpu_idx_t'(k);
      if (c >= cpu_idx_t'(n)) c = c - cpu_idx_t'(n);
      if (req[c]) next_rr = c;
    end
  endfunction
endpackage

// File: rtl/cpu_collector_fifo.sv
// cpu_collector_fifo: synchronous FIFO with read data presented at the head.
module cpu_collector_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/cpu_collector.sv
// cpu_collector: buffers per-cpu data beats and drains them round-robin onto one stream,
// with checksum, beat counting and completion tracking.
module cpu_collector
  import cpu_collector_pkg::*;
#(
  parameter int CPU_NB         = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TRANSACTION_NB = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CPU_NB-1:0]      cpu_data_vld,
  input  cpu_data_t [CPU_NB-1:0] cpu_data,
  input  logic [CPU_NB-1:0]      cpu_transactions_done,
  output logic                   out_vld,
  input  logic                   out_ready,
  output cpu_data_t              out_data,
  output cpu_idx_t               out_cpu_index,
  output logic [CPU_NB-1:0]      overflow,
  output logic [CPU_NB-1:0]      count_error,
  output cpu_data_t              checksum,
  output logic [31:0]            beat_count,
  output logic                   all_done
);
  localparam int IW = CPU_NB > 1 ? $clog2(CPU_NB) : 1;
  logic [CPU_NB-1:0] empty, full, push, pop, req;
  cpu_data_t rdata [CPU_NB];
  cpu_idx_t winner, rr_q, idx_q;
  logic load, out_vld_q, all_done_q;
  cpu_data_t out_data_q, sum_q;
  logic [31:0] beats_q;
  logic [31:0] recv_q [CPU_NB];
  logic [31:0] recv_d [CPU_NB];
  logic [CPU_NB-1:0] seen_q, ovf_q, err_q;
  for (genvar g = 0; g < CPU_NB; g++) begin : g_fifo
    cpu_collector_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (cpu_data[g]),
      .rdata_o (rdata[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end
  // A full FIFO still accepts a push when the output register drains it in the same cycle.
  always_comb begin
    req    = ~empty;
    load   = !out_vld_q || out_ready;
    winner = next_rr(rr_q, 32'(req), CPU_NB);
    pop    = '0;
    push   = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      pop[i]    = load && req[i] && winner == cpu_idx_t'(i);
      push[i]   = cpu_data_vld[i] && (!full[i] || pop[i]);
      recv_d[i] = recv_q[i] + {31'b0, cpu_data_vld[i] && recv_q[i] != '1};
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      sum_q      <= '0;
      beats_q    <= '0;
      seen_q     <= '0;
      ovf_q      <= '0;
      err_q      <= '0;
      all_done_q <= 1'b0;
      for (int i = 0; i < CPU_NB; i++) recv_q[i] <= '0;
    end else begin
      if (load) begin
        out_vld_q <= |req;
        if (|req) begin
          out_data_q <= rdata[winner[IW-1:0]];
          idx_q      <= winner;
          rr_q       <= (winner == cpu_idx_t'(CPU_NB - 1)) ? '0 : winner + 32'd1;
        end
      end
      if (out_vld_q && out_ready) begin
        sum_q   <= sum_q ^ out_data_q;
        beats_q <= beats_q + 32'd1;
      end
      all_done_q <= all_done_q | (&seen_q && &empty && !out_vld_q);
      for (int i = 0; i < CPU_NB; i++) begin
        recv_q[i] <= recv_d[i];
        if (cpu_data_vld[i] && full[i] && !pop[i]) ovf_q[i] <= 1'b1;
        if (cpu_transactions_done[i] && !seen_q[i]) begin
          seen_q[i] <= 1'b1;
          err_q[i]  <= recv_d[i] != 32'(TRANSACTION_NB);
        end else if (seen_q[i] && cpu_data_vld[i]) begin
          err_q[i] <= 1'b1;
        end
      end
    end
  assign out_vld       = out_vld_q;
  assign out_data      = out_data_q;
  assign out_cpu_index = idx_q;
  assign overflow      = ovf_q;
  assign count_error   = err_q;
  assign checksum      = sum_q;
  assign beat_count    = beats_q;
  assign all_done      = all_done_q;
endmodule

// File: tb/tb_cpu_collector.sv
// tb_cpu_collector: directed and randomized checks of cpu_collector against a queue-based model.
module tb_cpu_collector;
  import cpu_collector_pkg::*;
  localparam int N = 4, D = 4, TN = 3;
  logic clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [N-1:0] vld = '0, done = '0;
  cpu_data_t [N-1:0] data = '0;
  logic out_vld, all_done;
  cpu_data_t out_data, checksum;
  cpu_idx_t out_cpu_index;
  logic [N-1:0] overflow, count_error;
  logic [31:0] beat_count;
  int tests_run = 0, failures = 0;

  cpu_collector #(.CPU_NB(N), .FIFO_DEPTH(D), .TRANSACTION_NB(TN)) dut (
    .clk(clk), .rst(rst), .cpu_data_vld(vld), .cpu_data(data),
    .cpu_transactions_done(done), .out_vld(out_vld), .out_ready(ready),
    .out_data(out_data), .out_cpu_index(out_cpu_index), .overflow(overflow),
    .count_error(count_error), .checksum(checksum), .beat_count(beat_count),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  // Reference model: per-cpu queues, one held output beat, round-robin pointer.
  cpu_data_t mq [N][$];
  bit m_vld, m_alldone;
  cpu_data_t m_data, m_sum;
  int m_idx, m_ptr;
  bit [N-1:0] m_ovf, m_err, m_seen;
  logic [31:0] m_beats;
  longint m_recv [N];

  always @(posedge clk) begin
    bit idle, found;
    int c;
    if (rst) begin
      for (int i = 0; i < N; i++) begin mq[i].delete(); m_recv[i] = 0; end
      m_vld = 0; m_alldone = 0; m_data = '0; m_sum = '0; m_idx = 0; m_ptr = 0;
      m_ovf = '0; m_err = '0; m_seen = '0; m_beats = '0;
    end else begin
      idle = &m_seen && !m_vld;
      for (int i = 0; i < N; i++) if (mq[i].size() != 0) idle = 0;
      if (m_vld && ready) begin m_sum = m_sum ^ m_data; m_beats = m_beats + 1; end
      if (!m_vld || ready) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && mq[c].size() != 0) begin
            found = 1; m_data = mq[c].pop_front(); m_idx = c; m_ptr = (c + 1) % N;
          end
        end
        m_vld = found;
      end
      for (int i = 0; i < N; i++) begin
        if (vld[i]) begin
          if (mq[i].size() < D) mq[i].push_back(data[i]); else m_ovf[i] = 1;
          m_recv[i]++;
          if (m_seen[i]) m_err[i] = 1;
        end
        if (done[i] && !m_seen[i]) begin m_seen[i] = 1; m_err[i] = m_recv[i] != TN; end
      end
      m_alldone = m_alldone | idle;
    end
  end

  function automatic logic [201:0] dut_vec();
    return {out_vld, out_data, out_cpu_index, overflow, count_error, checksum, beat_count, all_done};
  endfunction
  function automatic logic [201:0] mdl_vec();
    return {m_vld, m_data, 32'(m_idx), m_ovf, m_err, m_sum, m_beats, m_alldone};
  endfunction

  task automatic tick(); @(negedge clk); endtask

  task automatic do_reset();
    rst = 1; vld = '0; done = '0; ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dut_vec() !== '0) begin failures++; $display("FAIL reset_state: got %h expected 0", dut_vec()); end
    tests_run++;
    if (dut_vec() !== mdl_vec()) begin failures++; $display("FAIL reset_model: got %h expected %h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_single();
    do_reset();
    vld = 4'b0100; data[2] = 64'h1234; tick(); vld = '0;
    tests_run++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL single_early: out_vld got %b expected 0", out_vld); end
    tick();
    tests_run++;
    if ({out_vld, out_cpu_index, out_data} !== {1'b1, 32'd2, 64'h1234}) begin
      failures++; $display("FAIL single_beat: got vld=%b idx=%0d data=%h expected 1 2 1234", out_vld, out_cpu_index, out_data);
    end
    ready = 1; tick(); ready = 0;
    tests_run++;
    if ({checksum, beat_count, out_vld} !== {64'h1234, 32'd1, 1'b0}) begin
      failures++; $display("FAIL single_accept: got sum=%h beats=%0d vld=%b expected 1234 1 0", checksum, beat_count, out_vld);
    end
  endtask

  task automatic test_all_cpus();
    do_reset();
    for (int i = 0; i < N; i++) data[i] = 64'(1) << i;
    vld = '1; ready = 1; tick(); vld = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      tests_run++;
      if ({out_vld, out_cpu_index, out_data} !== {1'b1, 32'(k), 64'(1) << k}) begin
        failures++; $display("FAIL all_cpus_order %0d: got vld=%b idx=%0d data=%h expected 1 %0d %h", k, out_vld, out_cpu_index, out_data, k, 64'(1) << k);
      end
    end
    tick();
    tests_run++;
    if ({checksum, beat_count} !== {64'hF, 32'd4}) begin
      failures++; $display("FAIL all_cpus_sum: got sum=%h beats=%0d expected f 4", checksum, beat_count);
    end
    ready = 0;
  endtask

  task automatic test_backpressure();
    cpu_data_t d [D+2];
    int got = 0;
    do_reset();
    for (int k = 0; k < D + 2; k++) begin
      d[k] = {$urandom, $urandom}; data[1] = d[k]; vld = 4'b0010; tick();
    end
    vld = '0;
    tests_run++;
    if (overflow !== 4'b0010) begin failures++; $display("FAIL bp_overflow: got %b expected 0010", overflow); end
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if ({out_vld, out_data} !== {1'b1, d[0]}) begin
        failures++; $display("FAIL bp_hold %0d: got vld=%b data=%h expected 1 %h", k, out_vld, out_data, d[0]);
      end
      tick();
    end
    ready = 1;
    for (int c = 0; c < 20; c++) begin
      if (out_vld) begin
        tests_run++;
        if (got >= D + 1 || out_data !== d[got]) begin
          failures++; $display("FAIL bp_data %0d: got %h expected %h", got, out_data, d[got < D + 1 ? got : 0]);
        end
        got++;
      end
      tick();
    end
    tests_run++;
    if (got != D + 1 || beat_count !== 32'(D + 1)) begin
      failures++; $display("FAIL bp_count: got beats=%0d/%0d expected %0d", got, beat_count, D + 1);
    end
    ready = 0;
  endtask

  task automatic test_fairness();
    int got = 0;
    do_reset();
    ready = 1; vld = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      data[0] = {$urandom, $urandom}; data[3] = {$urandom, $urandom};
      tick();
      if (out_vld) begin
        tests_run++;
        if (out_cpu_index !== ((got % 2) ? 32'd3 : 32'd0)) begin
          failures++; $display("FAIL fairness %0d: got idx %0d expected %0d", got, out_cpu_index, (got % 2) ? 3 : 0);
        end
        got++;
      end
    end
    vld = '0;
    tests_run++;
    if (got != 15) begin failures++; $display("FAIL fairness_rate: got %0d beats expected 15", got); end
    repeat (12) tick();
    ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vld = N'($urandom);
      for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom};
      ready = $urandom_range(0, 3) != 0;
      tick();
      tests_run++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL random_lockstep %0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    vld = '0; ready = 1;
    repeat (20) tick();
    tests_run++;
    if (dut_vec() !== mdl_vec()) begin failures++; $display("FAIL random_drain: got %h expected %h", dut_vec(), mdl_vec()); end
  endtask

  task automatic run_completion(input logic [N-1:0] last_mask, input logic [N-1:0] exp_err);
    do_reset();
    ready = 1;
    for (int r = 0; r < TN; r++) begin
      vld = (r == TN - 1) ? last_mask : '1;
      for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom};
      tick();
    end
    vld = '0; done = '1;
    for (int c = 0; c < 40 && !all_done; c++) begin
      tick();
      tests_run++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL completion_lockstep %0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    tests_run++;
    if ({all_done, count_error, beat_count} !== {1'b1, exp_err, 32'(TN * N - (N - $countones(last_mask)))}) begin
      failures++; $display("FAIL completion: got done=%b err=%b beats=%0d expected 1 %b", all_done, count_error, beat_count, exp_err);
    end
  endtask

  task automatic test_completion();
    run_completion('1, '0);
    run_completion(4'b1110, 4'b0001);
    vld = 4'b0010; tick(); vld = '0; tick();
    tests_run++;
    if ({all_done, count_error} !== {1'b1, 4'b0011}) begin
      failures++; $display("FAIL late_vld: got done=%b err=%b expected 1 0011", all_done, count_error);
    end
    done = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      vld = '1;
      for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom};
      tick();
    end
    vld = '0; rst = 1; tick();
    tests_run++;
    if (dut_vec() !== '0) begin failures++; $display("FAIL reset_mid: got %h expected 0", dut_vec()); end
    rst = 0; ready = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if ({out_vld, beat_count, checksum} !== '0) begin
        failures++; $display("FAIL reset_stale %0d: got vld=%b beats=%0d sum=%h expected 0", c, out_vld, beat_count, checksum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_cpus();
    test_backpressure();
    test_fairness();
    test_random();
    test_completion();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
